// File: rtl/shift_window_pkg.sv
// Shared definitions for the shift-window sequencer.
//   state_e     : sequencer states
//   WIN_BYTES   : bytes in a full window
//   FINAL_BYTES : bytes in the trailing final window
//   len_legal() : a segment must end on a full window or a single leftover byte
package shift_window_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StHold,
    StDone
  } state_e;

  localparam int unsigned WIN_BYTES   = 4;
  localparam int unsigned FINAL_BYTES = 1;

  // nonzero: len != 0; len_lsb: len[1:0]
  function automatic logic len_legal(input logic nonzero, input logic [1:0] len_lsb);
    return nonzero && ((len_lsb == 2'd0) || (len_lsb == 2'd1));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : clear to zero (wins over inc_i)
//   inc_i         : increment, holds at all-ones
//   cnt_o         : current count
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/shift_window_ctrl.sv
// Sequencer for the 4-byte window shift register. Reads one row segment of `len` bytes from
// the feature buffer, shifts it into the window register and hands each window to the PE array
// with a valid/ready handshake. A trailing single byte is emitted as a final window.
// Optional feature macro: SHIFT_WINDOW_CTRL_PERF_EN adds the stall_cnt output.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start, base_addr, len : segment request (sampled in idle only)
//   mem_rd, mem_addr    : buffer read strobe/address (1-cycle read latency)
//   sh_en, final_en     : shift-register controls
//   win_valid, win_ready: window handshake
//   busy, done, err     : status; done/err are single-cycle pulses
//   stall_cnt           : (perf build) cycles with win_valid && !win_ready, saturating
module shift_window_ctrl
  import shift_window_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  len,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              sh_en,
  output logic              final_en,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef SHIFT_WINDOW_CTRL_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [2:0]        cnt_q, cnt_d;   // cycle index within the current fill
  logic              final_q, final_d;
  logic              sh_en_q, sh_en_d;
  logic              err_q, err_d;
  logic [2:0]        win_n;
  logic              start_legal;

  assign start_legal = len_legal(|len, len[1:0]);
  assign win_n = (rem_q >= CNT_W'(WIN_BYTES)) ? 3'(WIN_BYTES) : 3'(FINAL_BYTES);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    final_d   = final_q;
    err_d     = 1'b0;
    mem_rd    = 1'b0;
    win_valid = 1'b0;
    final_en  = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (start_legal) begin
            addr_d  = base_addr;
            rem_d   = len;
            cnt_d   = 3'd0;
            final_d = 1'b0;
            state_d = StFill;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StFill: begin
        // Reads occupy the first n cycles; the extra cycle lets the last byte shift in.
        mem_rd = (cnt_q < win_n);
        cnt_d  = cnt_q + 3'd1;
        if (mem_rd) begin
          addr_d = addr_q + ADDR_W'(1);
        end
        if (cnt_q == win_n) begin
          cnt_d   = 3'd0;
          rem_d   = rem_q - CNT_W'(win_n);
          final_d = (win_n == 3'(FINAL_BYTES));
          state_d = StHold;
        end
      end
      StHold: begin
        win_valid = 1'b1;
        final_en  = final_q;
        if (win_ready) begin
          state_d = (rem_q == '0) ? StDone : StFill;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign sh_en_d = mem_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= 3'd0;
      final_q <= 1'b0;
      sh_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      final_q <= final_d;
      sh_en_q <= sh_en_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr = addr_q;
  assign sh_en    = sh_en_q;
  assign busy     = (state_q != StIdle);
  assign err      = err_q;

`ifdef SHIFT_WINDOW_CTRL_PERF_EN
  logic start_ok;
  assign start_ok = (state_q == StIdle) && start && start_legal;

  sat_counter #(
    .Width(16)
  ) u_stall_cnt (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (start_ok),
    .inc_i (win_valid && !win_ready),
    .cnt_o (stall_cnt)
  );
`endif

endmodule

// File: doc/shift_window_ctrl.md
# shift_window_ctrl

Sequencer for the 4-byte window shift register in the CNN datapath. Issues byte reads from the local feature buffer, drives the shift register's `sh_en` and `final_en`, and presents each completed 4-byte window to the PE array with a valid/ready handshake. It covers one row segment per `start`. The segment is a run of `len` bytes that ends either on a full window or on a single leftover byte, which is emitted as a final window.

## Interface
- `ADDR_W`, 8: feature-buffer address width.
- `CNT_W`, 8: width of `len` and of the remaining-byte counter.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a segment; sampled only in IDLE.
- `base_addr` in ADDR_W: first byte address, latched on accepted `start`.
- `len` in CNT_W: segment length in bytes, latched on accepted `start`.
- `mem_rd` out 1: buffer read strobe; read latency is 1 cycle.
- `mem_addr` out ADDR_W: read address.
- `sh_en` out 1: shift-register shift enable.
- `final_en` out 1: shift-register final-round select.
- `win_valid` out 1: the shift register holds a complete window.
- `win_ready` in 1: the PE array accepts the window.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last window is accepted.
- `err` out 1: one-cycle pulse when `start` carries an illegal `len`.

## Operation
- States: IDLE, FILL, HOLD, DONE.
- IDLE
  - `start`=1 with a legal `len` latches `base_addr` and `len`, then goes to FILL.
  - `len` is legal when `len`≠0 and `len[1:0]`∈{0,1}.
  - `start`=1 with an illegal `len` pulses `err` for 1 cycle and stays in IDLE.
- FILL
  - Window size n=4 when remaining ≥4, otherwise n=1 (the final window).
  - `mem_rd` is high for n consecutive cycles. `mem_addr` starts at `base_addr`+offset and increments by 1 per read, wrapping modulo 2^ADDR_W.
  - `sh_en` is `mem_rd` registered by one cycle, so each byte shifts in as it arrives.
  - FILL is left after the n-th `sh_en` cycle. Remaining decrements by n.
- HOLD
  - `win_valid`=1. `final_en`=1 only when the held window is the n=1 window.
  - `mem_rd` and `sh_en` stay 0, so the register contents are stable.
  - On `win_valid`&&`win_ready`: go to DONE when remaining=0, otherwise to FILL.
- DONE
  - `done`=1 for one cycle, then IDLE.
- `start` is ignored while `busy`=1.
- `len`=1 produces a single final window (1 read, `final_en`=1).

## Timing
- Reset value of every output is 0. The state returns to IDLE and all counters clear.
- Reset during FILL or HOLD abandons the segment. No `done` is produced.
- Full window: `start` accepted in cycle 0 → `mem_rd` in cycles 1–4 → `sh_en` in cycles 2–5 → `win_valid` from cycle 6.
- Final window: `mem_rd` in cycle k, `sh_en` in cycle k+1, `win_valid` with `final_en` from cycle k+2.
- Back-to-back windows: the handshake in cycle h puts the next `mem_rd` in cycle h+1.
- `done` is asserted in the cycle after the last handshake. `busy` falls in the cycle after `done`.
- `win_valid` is never deasserted before the handshake.
- `final_en` is never high outside HOLD.

## Configuration
- `SHIFT_WINDOW_CTRL_PERF_EN` defined:
  - Adds output `stall_cnt`, 16 bits.
  - It counts cycles with `win_valid`=1 and `win_ready`=0, saturating at 0xFFFF.
  - It clears on an accepted `start` and on reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `shift_window_pkg` holds:
  - the state enum;
  - `WIN_BYTES`=4;
  - `FINAL_BYTES`=1;
  - the legality function for `len`.
- One sub-module, `sat_counter`, a parameterised saturating counter. It is instantiated only under `SHIFT_WINDOW_CTRL_PERF_EN`.

## Test plan
- `len`=8, `base_addr`=0x10, `win_ready` tied 1 → reads 0x10–0x17, two windows with `final_en`=0, then one `done` pulse.
- `len`=5, `base_addr`=0x20 → first window reads 0x20–0x23; second window reads 0x24 only, with `final_en`=1 throughout its HOLD.
- `len`=4, `win_ready` low for 3 cycles of HOLD → no `mem_rd`/`sh_en` during the stall, window stable, `stall_cnt`=3 with the macro defined.
- `len`=6, then `len`=0 → `err` pulses each time, no `mem_rd`, `busy` stays 0. A `start` during `busy` is ignored.
- `base_addr`=0xFE, `len`=4 → `mem_addr` sequence 0xFE, 0xFF, 0x00, 0x01.
- `rst_n` low in cycle 3 of FILL → all outputs 0 immediately. A new `start` after release runs a full segment correctly.
